// File: rtl/controlador_intermitentes_pkg.sv
// Shared definitions for the turn-signal / hazard controller: mode codes,
// default 50 MHz timing and the request priority resolver.
package controlador_intermitentes_pkg;

   // Mode encoding as seen on the Modo output
   localparam logic [1:0] MODO_REPOSO = 2'd0;
   localparam logic [1:0] MODO_IZQ    = 2'd1;
   localparam logic [1:0] MODO_DER    = 2'd2;
   localparam logic [1:0] MODO_EMERG  = 2'd3;

   // Default timing for a 50 MHz clock: 1 s period, 200 ms ON window
   localparam int PERIOD_CYC_DEF = 50_000_000;
   localparam int ON_CYC_DEF     = 10_000_000;
   localparam int NUM_LAMPS_DEF  = 3;

   // Hazard wins, both indicators together also mean hazard,
   // otherwise a single side, otherwise idle.
   function automatic logic [1:0] resolver_modo(input logic emerg,
                                                input logic izq,
                                                input logic der);
      logic [1:0] modo;
      if (emerg)            modo = MODO_EMERG;
      else if (izq && der)  modo = MODO_EMERG;
      else if (izq)         modo = MODO_IZQ;
      else if (der)         modo = MODO_DER;
      else                  modo = MODO_REPOSO;
      return modo;
   endfunction

endpackage

// File: rtl/controlador_intermitentes_generador_fase.sv
// Blink phase generator: period counter plus a step counter and lamp index
// that track which sweep lamp is reached, so no divider is needed.
module generador_fase #(
   parameter int PERIOD_CYC = 50_000_000,
   parameter int ON_CYC     = 10_000_000,
   parameter int NUM_LAMPS  = 3,
   parameter int CNT_W      = $clog2(PERIOD_CYC),
   parameter int IDX_W      = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1
) (
   input  logic             Reloj,
   input  logic             Reset_n,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] lamp_idx,
   output logic             en_on,
   output logic             fin_periodo
);

   localparam int STEP_CYC = ON_CYC / NUM_LAMPS;
   localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_CYC - 1);
   localparam logic [CNT_W-1:0]  ON_LIM    = CNT_W'(ON_CYC);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LAMPS - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [IDX_W-1:0]  idx_q,  idx_d;

   assign en_on       = (cnt_q < ON_LIM);
   assign fin_periodo = (cnt_q == CNT_LAST);
   assign cnt         = cnt_q;
   assign lamp_idx    = idx_q;

   // Next phase: restart on clear/idle/wrap, otherwise advance; the lamp
   // index only moves inside the ON window and saturates at the last lamp.
   always_comb begin
      cnt_d  = cnt_q;
      step_d = step_q;
      idx_d  = idx_q;
      if (clear || !enable || fin_periodo) begin
         cnt_d  = '0;
         step_d = '0;
         idx_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         if (en_on) begin
            if (step_q == STEP_LAST) begin
               step_d = '0;
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               step_d = step_q + STEP_ONE;
            end
         end
      end
   end

   // Phase state registers
   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q  <= '0;
         step_q <= '0;
         idx_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/controlador_intermitentes.sv
// Turn-signal and hazard controller: synchronizes the panel requests,
// arbitrates them into one mode and drives two sweeping lamp banks from a
// single shared phase generator.
module controlador_intermitentes
   import controlador_intermitentes_pkg::*;
#(
   parameter int PERIOD_CYC = PERIOD_CYC_DEF,
   parameter int ON_CYC     = ON_CYC_DEF,
   parameter int NUM_LAMPS  = NUM_LAMPS_DEF
) (
   input  logic                 Reloj,
   input  logic                 Reset_n,
   input  logic                 Izq,
   input  logic                 Der,
   input  logic                 Emergencia,
   output logic [NUM_LAMPS-1:0] LED_Izq,
   output logic [NUM_LAMPS-1:0] LED_Der,
   output logic [1:0]           Modo,
   output logic                 Pulso_Periodo
);

   localparam int CNT_W = $clog2(PERIOD_CYC);
   localparam int IDX_W = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;

   // Request bits are kept as {emergencia, der, izq}
   logic [2:0] sync1_q, sync2_q;
   logic [1:0] modo_q, modo_d;
   logic [NUM_LAMPS-1:0] led_izq_q, led_izq_d;
   logic [NUM_LAMPS-1:0] led_der_q, led_der_d;
   logic pulso_q, pulso_d;

   logic clear, enable;
   logic [CNT_W-1:0] cnt_fase;
   logic [IDX_W-1:0] lamp_idx;
   logic en_on, fin_periodo;
   logic [NUM_LAMPS-1:0] barrido;
   // The raw phase count is only a debug tap; the outputs use the decoded
   // window/index instead.
   logic cnt_unused;

   assign cnt_unused = ^cnt_fase;

   // Two-flop synchronizers for the asynchronous panel switches
   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {Emergencia, Der, Izq};
         sync2_q <= sync1_q;
      end
   end

   assign modo_d = resolver_modo(sync2_q[2], sync2_q[0], sync2_q[1]);

   // Mode register reloads the arbitrated request every cycle
   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) modo_q <= MODO_REPOSO;
      else          modo_q <= modo_d;
   end

   // A mode change restarts the phase on the same edge; idle holds it at 0
   assign clear  = (modo_d != modo_q);
   assign enable = (modo_q != MODO_REPOSO);

   generador_fase #(
      .PERIOD_CYC (PERIOD_CYC),
      .ON_CYC     (ON_CYC),
      .NUM_LAMPS  (NUM_LAMPS),
      .CNT_W      (CNT_W),
      .IDX_W      (IDX_W)
   ) u_generador_fase (
      .Reloj       (Reloj),
      .Reset_n     (Reset_n),
      .clear       (clear),
      .enable      (enable),
      .cnt         (cnt_fase),
      .lamp_idx    (lamp_idx),
      .en_on       (en_on),
      .fin_periodo (fin_periodo)
   );

   // Sweep pattern: every lamp up to the current index is lit in the ON window
   generate
      for (genvar gi = 0; gi < NUM_LAMPS; gi++) begin : g_barrido
         assign barrido[gi] = en_on && (lamp_idx >= IDX_W'(gi));
      end
   endgenerate

   // Route the sweep to the bank(s) selected by the current mode
   always_comb begin
      led_izq_d = '0;
      led_der_d = '0;
      case (modo_q)
         MODO_IZQ:   led_izq_d = barrido;
         MODO_DER:   led_der_d = barrido;
         MODO_EMERG: begin
            led_izq_d = barrido;
            led_der_d = barrido;
         end
         default: ;
      endcase
      pulso_d = enable && fin_periodo;
   end

   // Registered lamp and period-strobe outputs
   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
         led_izq_q <= '0;
         led_der_q <= '0;
         pulso_q   <= 1'b0;
      end else begin
         led_izq_q <= led_izq_d;
         led_der_q <= led_der_d;
         pulso_q   <= pulso_d;
      end
   end

   assign LED_Izq       = led_izq_q;
   assign LED_Der       = led_der_q;
   assign Modo          = modo_q;
   assign Pulso_Periodo = pulso_q;

endmodule

// File: tb/tb_controlador_intermitentes.sv
// Self-checking bench for controlador_intermitentes with a small-period
// configuration; a per-edge behavioural model is compared every cycle.
module tb_controlador_intermitentes;

   localparam int P    = 20;
   localparam int ON   = 6;
   localparam int N    = 3;
   localparam int STEP = ON / N;

   logic Reloj = 1'b0;
   logic Reset_n = 1'b0;
   logic Izq = 1'b0, Der = 1'b0, Emergencia = 1'b0;
   logic [N-1:0] LED_Izq, LED_Der;
   logic [1:0] Modo;
   logic Pulso_Periodo;

   int tests = 0;
   int fails = 0;

   // Model state: raw pin samples of the last three edges, current mode and
   // how many edges it has been held, plus the expected registered outputs.
   logic [2:0] hist[$];
   int m_mode;
   int m_age;
   logic [N-1:0] e_izq, e_der;
   int e_modo;
   logic e_pulso;

   controlador_intermitentes #(
      .PERIOD_CYC (P),
      .ON_CYC     (ON),
      .NUM_LAMPS  (N)
   ) dut (
      .Reloj         (Reloj),
      .Reset_n       (Reset_n),
      .Izq           (Izq),
      .Der           (Der),
      .Emergencia    (Emergencia),
      .LED_Izq       (LED_Izq),
      .LED_Der       (LED_Der),
      .Modo          (Modo),
      .Pulso_Periodo (Pulso_Periodo)
   );

   always #5 Reloj = ~Reloj;

   function automatic logic [N-1:0] sweep(input int c);
      int v;
      logic [31:0] w;
      if (c < ON) v = (1 << (c / STEP + 1)) - 1;
      else        v = 0;
      w = v;
      return w[N-1:0];
   endfunction

   function automatic int resolve(input logic [2:0] s); // {emerg, der, izq}
      if (s[2])              return 3;
      if (s[0] && s[1])      return 3;
      if (s[0])              return 1;
      if (s[1])              return 2;
      return 0;
   endfunction

   function automatic int m_phase();
      return (m_mode == 0) ? 0 : (m_age % P);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (3) hist.push_back(3'b000);
      m_mode = 0; m_age = 0;
      e_izq = '0; e_der = '0; e_modo = 0; e_pulso = 1'b0;
   endtask

   // One clock: advance the model at the edge, compare at the falling edge
   task automatic cycle();
      int ph, nm;
      @(posedge Reloj);
      if (!Reset_n) begin
         model_reset();
      end else begin
         ph = m_phase();
         e_izq   = (m_mode == 1 || m_mode == 3) ? sweep(ph) : '0;
         e_der   = (m_mode == 2 || m_mode == 3) ? sweep(ph) : '0;
         e_pulso = (m_mode != 0) && (ph == P - 1);
         hist.push_back({Emergencia, Der, Izq});
         void'(hist.pop_front());
         nm = resolve(hist[0]);
         if (nm != m_mode)  m_age = 0;
         else if (nm != 0)  m_age++;
         m_mode = nm;
         e_modo = nm;
      end
      @(negedge Reloj);
      check("modo",    int'(Modo),          e_modo);
      check("led_izq", int'(LED_Izq),       int'(e_izq));
      check("led_der", int'(LED_Der),       int'(e_der));
      check("pulso",   int'(Pulso_Periodo), int'(e_pulso));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Advance until the model reaches mode md at phase ph (bounded)
   task automatic wait_phase(input string name, input int md, input int ph);
      int k;
      k = 0;
      while (!(m_mode == md && m_phase() == ph) && k < 200) begin
         cycle();
         k++;
      end
      if (k >= 200) check(name, 0, 1);
   endtask

   function automatic int lit_izq(input int k);
      if (k <= 3)  return 0;
      if (k <= 5)  return 1;
      if (k <= 7)  return 3;
      if (k <= 9)  return 7;
      if (k <= 23) return 0;
      return 1;
   endfunction

   initial begin
      int pulses, hold, r;
      model_reset();

      // Reset held with Izq requested: everything stays dark
      Izq = 1'b1;
      run(3);
      check("reset_modo", int'(Modo), 0);
      check("reset_leds", int'({LED_Izq, LED_Der}), 0);
      Reset_n = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         cycle();
         check("lit_izq", int'(LED_Izq), lit_izq(k));
         check("lit_der", int'(LED_Der), 0);
         check("lit_modo", int'(Modo), (k >= 3) ? 1 : 0);
         check("lit_pulso", int'(Pulso_Periodo), (k == 23) ? 1 : 0);
      end
      $display("[TB] txn reset_release_izq tests=%0d", tests);

      // Right indicator across three periods: one strobe per period
      Izq = 1'b0; Der = 1'b1;
      run(5);
      pulses = 0;
      for (int i = 0; i < 3 * P; i++) begin
         cycle();
         if (Pulso_Periodo) pulses++;
      end
      check("pulses_der", pulses, 3);
      $display("[TB] txn der_three_periods pulses=%0d", pulses);

      // Both sides together resolve to hazard, banks in phase
      Izq = 1'b1;
      run(30);
      check("both_modo", int'(Modo), 3);
      $display("[TB] txn izq_der_hazard tests=%0d", tests);

      // Hazard preempting an active left indicator, then released
      Der = 1'b0;
      wait_phase("wait_izq_ph3", 1, 3);
      Emergencia = 1'b1;
      run(3);
      check("preempt_modo", int'(Modo), 3);
      run(10);
      Emergencia = 1'b0;
      run(30);
      $display("[TB] txn hazard_preempt tests=%0d", tests);

      // Left dropped mid window: dark and idle at the fixed latency
      wait_phase("wait_izq_ph4", 1, 4);
      Izq = 1'b0;
      run(3);
      check("drop_modo", int'(Modo), 0);
      cycle();
      check("drop_led", int'(LED_Izq), 0);
      run(10);
      $display("[TB] txn izq_drop tests=%0d", tests);

      // Reset asserted mid ON window clears outputs without a clock edge
      Izq = 1'b1;
      wait_phase("wait_izq_ph2", 1, 2);
      #1 Reset_n = 1'b0;
      #1;
      check("async_modo",  int'(Modo), 0);
      check("async_leds",  int'({LED_Izq, LED_Der}), 0);
      check("async_pulso", int'(Pulso_Periodo), 0);
      run(2);
      Reset_n = 1'b1;
      run(30);
      $display("[TB] txn async_reset tests=%0d", tests);

      // Random request patterns with occasional resets
      for (int s = 0; s < 80; s++) begin
         r = int'($urandom_range(0, 7));
         Izq        = r[0];
         Der        = r[1];
         Emergencia = r[2] && ($urandom_range(0, 2) == 0);
         hold = int'($urandom_range(1, 45));
         if ($urandom_range(0, 19) == 0) begin
            #1 Reset_n = 1'b0;
            #1;
            check("rnd_async", int'({Modo, LED_Izq, LED_Der, Pulso_Periodo}), 0);
            run(1);
            Reset_n = 1'b1;
         end
         run(hold);
      end
      $display("[TB] txn random_segments tests=%0d", tests);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
